// File: rtl/dff_climax_counter.sv
// Combo/streak tracker for a single per-cycle niceplay strobe.
// Counts consecutive niceplay cycles, enters CLIMAX once the streak reaches
// CLIMAX_THRESH, and holds off for COOLDOWN_CYCLES after a climax streak
// breaks. Every output is a register; nothing is combinational from niceplay.
module dff_climax_counter #(
    parameter int CLIMAX_THRESH   = 4,   // 1..255
    parameter int COOLDOWN_CYCLES = 3    // 0..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       niceplay,
    output logic       climax,
    output logic [7:0] count,
    output logic [2:0] contents
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STREAK   = 3'd1,
        CLIMAX   = 3'd2,
        COOLDOWN = 3'd3
    } state_t;

    // Threshold widened by one bit so the compare against count+1 never wraps.
    localparam logic [8:0] THRESH    = 9'(CLIMAX_THRESH);
    localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_CYCLES);

    state_t     state_reg, state_next;
    logic [7:0] count_reg, count_next;
    logic [7:0] cool_reg,  cool_next;
    logic       climax_reg;
    logic [8:0] count_inc;

    // Pre-increment value + 1, used both for the threshold test and the update.
    assign count_inc = {1'b0, count_reg} + 9'd1;

    // Next-state and next-count decisions for the streak state machine.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        cool_next  = cool_reg;
        case (state_reg)
            IDLE: begin
                if (niceplay) begin
                    count_next = 8'd1;
                    state_next = (THRESH == 9'd1) ? CLIMAX : STREAK;
                end else begin
                    count_next = 8'd0;
                end
            end
            STREAK: begin
                if (niceplay) begin
                    count_next = count_inc[7:0];
                    if (count_inc == THRESH) begin
                        state_next = CLIMAX;
                    end
                end else begin
                    // A streak that never climaxed gets no cooldown.
                    count_next = 8'd0;
                    state_next = IDLE;
                end
            end
            CLIMAX: begin
                if (niceplay) begin
                    // Saturate at 255 rather than wrapping back to zero.
                    if (count_reg != 8'hFF) begin
                        count_next = count_inc[7:0];
                    end
                end else begin
                    count_next = 8'd0;
                    if (COOL_LOAD == 8'd0) begin
                        cool_next  = 8'd0;
                        state_next = IDLE;
                    end else begin
                        cool_next  = COOL_LOAD;
                        state_next = COOLDOWN;
                    end
                end
            end
            COOLDOWN: begin
                // niceplay is ignored; leave once the last cooldown cycle is used.
                count_next = 8'd0;
                if (cool_reg <= 8'd1) begin
                    cool_next  = 8'd0;
                    state_next = IDLE;
                end else begin
                    cool_next  = cool_reg - 8'd1;
                end
            end
            default: begin
                // Unused codes recover to IDLE with a cleared streak.
                state_next = IDLE;
                count_next = 8'd0;
                cool_next  = 8'd0;
            end
        endcase
    end

    // State, streak, cooldown and climax registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= 8'd0;
            cool_reg   <= 8'd0;
            climax_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            cool_reg   <= cool_next;
            climax_reg <= (state_next == CLIMAX);
        end
    end

    assign climax   = climax_reg;
    assign count    = count_reg;
    assign contents = state_reg;

endmodule

// File: tb/tb_dff_climax_counter.sv
// Bench for dff_climax_counter: three instances (default, threshold 1,
// zero cooldown) driven by the same stimulus and checked every cycle against
// a run-length model, plus literal expectations at key points.
module tb_dff_climax_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       niceplay = 1'b0;
    logic       clx  [3];
    logic [7:0] cnt  [3];
    logic [2:0] cont [3];

    int checks = 0;
    int errors = 0;
    bit model_valid = 1'b0;

    // Model: length of the current run of ones, and remaining cooldown cycles.
    int thr  [3] = '{4, 1, 4};
    int cdn  [3] = '{3, 3, 0};
    int run  [3];
    int cool [3];

    always #5 clk = ~clk;

    dff_climax_counter #(.CLIMAX_THRESH(4), .COOLDOWN_CYCLES(3)) dut0 (
        .clk(clk), .rst(rst), .niceplay(niceplay),
        .climax(clx[0]), .count(cnt[0]), .contents(cont[0]));
    dff_climax_counter #(.CLIMAX_THRESH(1), .COOLDOWN_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .niceplay(niceplay),
        .climax(clx[1]), .count(cnt[1]), .contents(cont[1]));
    dff_climax_counter #(.CLIMAX_THRESH(4), .COOLDOWN_CYCLES(0)) dut2 (
        .clk(clk), .rst(rst), .niceplay(niceplay),
        .climax(clx[2]), .count(cnt[2]), .contents(cont[2]));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_state(input int i);
        if (cool[i] > 0)       return 3;
        else if (run[i] == 0)  return 0;
        else if (run[i] >= thr[i]) return 2;
        else                   return 1;
    endfunction

    function automatic int model_count(input int i);
        return (cool[i] > 0) ? 0 : run[i];
    endfunction

    // One clock edge: drive inputs, advance the model, settle just past the edge.
    task automatic step(input bit r, input bit np);
        rst = r;
        niceplay = np;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                run[i] = 0; cool[i] = 0;
            end else if (cool[i] > 0) begin
                cool[i]--; run[i] = 0;
            end else if (np) begin
                run[i] = (run[i] < 255) ? run[i] + 1 : 255;
            end else begin
                if (run[i] >= thr[i]) cool[i] = cdn[i];
                run[i] = 0;
            end
        end
        model_valid = 1'b1;
        #1;
        $display("edge t=%0t rst=%0d np=%0d | d0 cnt=%0d st=%0d clx=%0d | d1 st=%0d | d2 st=%0d",
                 $time, r, np, cnt[0], cont[0], clx[0], cont[1], cont[2]);
    endtask

    task automatic pin(input string name, input int i, input int c, input int s, input int x);
        check({name, ".count"},    cnt[i],  c);
        check({name, ".contents"}, cont[i], s);
        check({name, ".climax"},   clx[i],  x);
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("model%0d.count", i),    cnt[i],  model_count(i));
                check($sformatf("model%0d.contents", i), cont[i], model_state(i));
                check($sformatf("model%0d.climax", i),   clx[i],  model_state(i) == 2);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin run[i] = 0; cool[i] = 0; end
        @(negedge clk);

        // Reset held two edges with niceplay toggling.
        step(1, 1); pin("rst_a", 0, 0, 0, 0);
        step(1, 0); pin("rst_b", 0, 0, 0, 0);

        // Single pulse, gap, then a five-cycle run into CLIMAX.
        step(0, 1); pin("pulse", 0, 1, 1, 0);
        step(0, 0); pin("gap", 0, 0, 0, 0);
        step(0, 1); pin("run1", 0, 1, 1, 0);
        step(0, 1); pin("run2", 0, 2, 1, 0);
        step(0, 1); pin("run3", 0, 3, 1, 0);
        step(0, 1); pin("run4", 0, 4, 2, 1);
        step(0, 1); pin("run5", 0, 5, 2, 1);
        step(0, 0); pin("cd1", 0, 0, 3, 0);
        step(0, 0); pin("cd2", 0, 0, 3, 0);
        step(0, 0); pin("cd3", 0, 0, 3, 0);
        step(0, 0); pin("cd_exit", 0, 0, 0, 0);

        // Break before threshold: no climax, no cooldown.
        step(0, 1); pin("brk1", 0, 1, 1, 0);
        step(0, 1); pin("brk2", 0, 2, 1, 0);
        step(0, 1); pin("brk3", 0, 3, 1, 0);
        step(0, 0); pin("brk_end", 0, 0, 0, 0);

        // Cooldown ignores niceplay, then a fresh streak starts.
        repeat (4) step(0, 1);
        step(0, 0); pin("cdi1", 0, 0, 3, 0);
        step(0, 1); pin("cdi2", 0, 0, 3, 0);
        step(0, 1); pin("cdi3", 0, 0, 3, 0);
        step(0, 1); pin("cdi_exit", 0, 0, 0, 0);
        step(0, 1); pin("cdi_new", 0, 1, 1, 0);

        // Reset in the middle of CLIMAX.
        step(1, 0);
        step(0, 1); pin("thr1_first", 1, 1, 2, 1);
        repeat (9) step(0, 1);
        pin("pre_rst", 0, 10, 2, 1);
        step(1, 0); pin("mid_rst", 0, 0, 0, 0);
        step(0, 0); pin("no_cd", 0, 0, 0, 0);

        // Saturation over 300 cycles, then break.
        for (int k = 1; k <= 300; k++) begin
            step(0, 1);
            if (k == 4)   pin("sat4", 0, 4, 2, 1);
            if (k == 255) pin("sat255", 0, 255, 2, 1);
        end
        pin("sat300", 0, 255, 2, 1);
        step(0, 0);
        pin("cd0_direct", 2, 0, 0, 0);
        pin("cd3_entry", 0, 0, 3, 0);
        repeat (4) step(0, 0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
